cache_axi_bridge: RTL and testbench
===================================

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd1: value driven on arid/awid; bid/rid are not checked.
REQ-002 Parameter LINE_BEATS, default `WIDTH/4 (4): words per cache-line burst.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 rd_req  in  1  cache read request; accepted when rd_req && rd_rdy.
REQ-006 rd_type  in  3  000 byte, 001 half, 010 word, 100 cache line.
REQ-007 rd_addr  in  32  read address; line reads are 16-byte aligned.
REQ-008 rd_rdy  out  1  bridge can accept a read this cycle.
REQ-009 ret_valid / ret_last / ret_data  out  1/1/32  returned read beat, last-beat flag, beat data.
REQ-010 wr_req  in  1  cache write request; accepted when wr_req && wr_rdy.
REQ-011 wr_type / wr_addr / wr_wstrb / wr_data  in  3/32/4/`WIDTH*8  write type, address, word strobe (types 000/001/010 only), line data.
REQ-012 wr_rdy  out  1  bridge can accept a write this cycle.
REQ-013 AR channel  out arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1; in arready 1.
REQ-014 R channel  in rid 4, rdata 32, rresp 2, rlast 1, rvalid 1; out rready 1.
REQ-015 AW channel  out awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1; in awready 1.
REQ-016 W channel  out wdata 32, wstrb 4, wlast 1, wvalid 1; in wready 1.
REQ-017 B channel  in bid 4, bresp 2, bvalid 1; out bready 1.
REQ-018 axi_err  out  1  sticky flag: some rresp or bresp != 2'b00 was received.

Function
REQ-019 Read FSM states R_IDLE -> R_ADDR -> R_DATA -> R_IDLE; write FSM states W_IDLE -> W_SEND -> W_RESP -> W_IDLE; the two FSMs run concurrently.
REQ-020 A read is accepted in R_IDLE; at acceptance it latches the address and sets arlen = (type==100) ? LINE_BEATS-1 : 0 and arsize = (type==100) ? 3'b010 : type[1:0].
REQ-021 arburst and awburst are always 2'b01 (INCR).
REQ-022 R_ADDR holds arvalid=1 with stable fields until arready, then moves to R_DATA; arvalid is 0 in every other state.
REQ-023 rready=1 only in R_DATA; ret_valid = rvalid && R_DATA, ret_data = rdata, ret_last = rlast, all combinational, zero added latency.
REQ-024 A beat with rlast returns the FSM to R_IDLE, so the earliest next read is accepted one cycle later.
REQ-025 A write is accepted in W_IDLE; at acceptance it latches addr, type, wstrb and the full `WIDTH*8 data; awlen and awsize follow the REQ-020 rule using wr_type.
REQ-026 W_SEND: awvalid is held until awready and then drops; wvalid is asserted independently of the AW handshake.
REQ-027 wdata = latched data[beat*32 +: 32] with beat counting 0..awlen; beat increments on wvalid && wready.
REQ-028 wstrb = 4'hf for line writes and the latched wr_wstrb otherwise; wlast = (beat == awlen).
REQ-029 W_SEND moves to W_RESP once both the AW handshake and the wlast handshake are done, in either order or in the same cycle.
REQ-030 W_RESP holds bready=1 and returns to W_IDLE on bvalid.
REQ-031 wr_rdy = W_IDLE.
REQ-032 rd_rdy = R_IDLE && !hazard, where hazard = (write FSM not idle and rd_addr[31:4] == latched wr_addr[31:4]) or (wr_req and rd_addr[31:4] == wr_addr[31:4]).
REQ-033 When wr_req and rd_req arrive in the same cycle for different lines, both are accepted.
REQ-034 axi_err sets on (rvalid && rready && rresp != 0) or (bvalid && bready && bresp != 0), and clears only on reset.

Reset
REQ-035 On reset assertion, with no clock required: both FSMs go idle, beat = 0, axi_err = 0, all valid/ready outputs and ret_* are 0, and rd_rdy/wr_rdy become 1.
REQ-036 An AXI transaction in flight at reset is abandoned; the interconnect is reset by the same signal.

Structure
REQ-037 The type encodings (BYTE/HALF/WORD/LINE), the INCR burst value and the FSM state encodings belong in the shared cache.vh header beside `WIDTH.
REQ-038 One sub-module, axi_wbeat_ser, holds the latched line, the beat counter and the wdata/wstrb/wlast generation.

Verification
REQ-039 Line read to 0x1C000010 with arready after 2 cycles and R beats 0xA,0xB,0xC,0xD: expect arlen=3, arsize=2, four ret_valid beats in order, and ret_last on 0xD only.
REQ-040 Uncached word write to 0xBFAF8000 with wstrb=4'b0011: expect awlen=0, a single beat with wlast=1 and wstrb=0011, wr_rdy=0 until bvalid, then 1.
REQ-041 Line write (data 128'h4444_..._1111) with wready toggling and awready arriving after wlast: expect beats in order 0x1111...,...,0x4444... and W_RESP entered only after awready.
REQ-042 Write to 0x00001000 pending, then read to 0x00001004: expect rd_rdy=0 until bvalid, and arvalid only afterwards.
REQ-043 Same-cycle line write 0x2000 and line read 0x3000: expect both accepted and the AR and AW channels active concurrently.
REQ-044 Assert reset mid-burst (beat 2) with bresp=2'b10 seen earlier: expect all valids=0, axi_err=0, and both FSMs idle before the next clk edge.

Source files
------------

// File: rtl/cache_axi_bridge_pkg.sv
// Shared definitions for the cache-to-AXI bridge: line geometry, request
// type encodings, burst type and FSM state encodings.
package cache_axi_bridge_pkg;

  localparam int unsigned WIDTH    = 16;             // cache line size in bytes
  localparam int unsigned LINE_LSB = $clog2(WIDTH);  // lowest line-index address bit

  typedef enum logic [2:0] {
    TYPE_BYTE = 3'b000,
    TYPE_HALF = 3'b001,
    TYPE_WORD = 3'b010,
    TYPE_LINE = 3'b100
  } req_type_e;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } wr_state_e;

  // AXI burst length (beats - 1) for a cache request type
  function automatic logic [7:0] burst_len(input logic [2:0] t, input int unsigned beats);
    return (t == TYPE_LINE) ? 8'(beats - 1) : 8'd0;
  endfunction

  // AXI beat size; line bursts move full 32-bit words
  function automatic logic [2:0] burst_size(input logic [2:0] t);
    return (t == TYPE_LINE) ? 3'b010 : {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/cache_axi_bridge_wbeat_ser.sv
// Write-beat serializer: holds the latched write line and strobe, counts
// accepted W beats and presents wdata/wstrb/wlast for the current beat.
module axi_wbeat_ser
  import cache_axi_bridge_pkg::*;
#(
  parameter int unsigned LINE_BEATS = WIDTH / 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [WIDTH*8-1:0]   line_i,
  input  logic [3:0]           wstrb_i,
  input  logic                 is_line_i,
  input  logic [7:0]           len_i,
  input  logic                 step_i,
  output logic [31:0]          wdata_o,
  output logic [3:0]           wstrb_o,
  output logic                 wlast_o
);

  localparam int unsigned BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  logic [WIDTH*8-1:0] line_q, line_d;
  logic [3:0]         strb_q, strb_d;
  logic [BW-1:0]      beat_q, beat_d;

  // Line/strobe/beat registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= '0;
      strb_q <= '0;
      beat_q <= '0;
    end else begin
      line_q <= line_d;
      strb_q <= strb_d;
      beat_q <= beat_d;
    end
  end

  // Load a new write at acceptance; otherwise advance on each W handshake
  always_comb begin
    line_d = line_q;
    strb_d = strb_q;
    beat_d = beat_q;
    if (load_i) begin
      line_d = line_i;
      strb_d = is_line_i ? 4'hf : wstrb_i;
      beat_d = '0;
    end else if (step_i) begin
      beat_d = beat_q + BW'(1);
    end
  end

  assign wdata_o = line_q[beat_q*32 +: 32];
  assign wstrb_o = strb_q;
  assign wlast_o = (8'(beat_q) == len_i);

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge: independent read and write FSMs translating cache
// byte/half/word/line requests into single AXI transactions, with a
// same-line read-after-write hazard block and a sticky response error flag.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter logic [3:0]  AXI_ID     = 4'd1,
  parameter int unsigned LINE_BEATS = WIDTH / 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_req,
  input  logic [2:0]         rd_type,
  input  logic [31:0]        rd_addr,
  output logic               rd_rdy,
  output logic               ret_valid,
  output logic               ret_last,
  output logic [31:0]        ret_data,
  input  logic               wr_req,
  input  logic [2:0]         wr_type,
  input  logic [31:0]        wr_addr,
  input  logic [3:0]         wr_wstrb,
  input  logic [WIDTH*8-1:0] wr_data,
  output logic               wr_rdy,
  output logic [3:0]         arid,
  output logic [31:0]        araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  input  logic [3:0]         rid,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic [3:0]         awid,
  output logic [31:0]        awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic [3:0]         bid,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic               axi_err
);

  rd_state_e   rstate_q, rstate_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;

  wr_state_e   wstate_q, wstate_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [7:0]  awlen_q, awlen_d;
  logic [2:0]  awsize_q, awsize_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_q, err_d;

  logic hazard, rd_acc, wr_acc, aw_hs, wlast_hs;

  // Response IDs are not checked
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  // A read must not overtake a write to the same line, pending or arriving now
  assign hazard = ((wstate_q != W_IDLE) && (rd_addr[31:LINE_LSB] == awaddr_q[31:LINE_LSB])) ||
                  (wr_req && (rd_addr[31:LINE_LSB] == wr_addr[31:LINE_LSB]));
  assign rd_rdy = (rstate_q == R_IDLE) && !hazard;
  assign wr_rdy = (wstate_q == W_IDLE);
  assign rd_acc = rd_req && rd_rdy;
  assign wr_acc = wr_req && wr_rdy;

  assign arid      = AXI_ID;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = BURST_INCR;
  assign arvalid   = (rstate_q == R_ADDR);
  assign rready    = (rstate_q == R_DATA);
  assign ret_valid = rvalid && (rstate_q == R_DATA);
  assign ret_last  = ret_valid && rlast;
  assign ret_data  = ret_valid ? rdata : '0;

  assign awid    = AXI_ID;
  assign awaddr  = awaddr_q;
  assign awlen   = awlen_q;
  assign awsize  = awsize_q;
  assign awburst = BURST_INCR;
  assign awvalid = (wstate_q == W_SEND) && !aw_done_q;
  assign wvalid  = (wstate_q == W_SEND) && !w_done_q;
  assign bready  = (wstate_q == W_RESP);
  assign aw_hs   = awvalid && awready;
  assign wlast_hs = wvalid && wready && wlast;
  assign axi_err = err_q;

  // All bridge state registers, abandoned immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      wstate_q  <= W_IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      wstate_q  <= wstate_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  // Read FSM: latch request, present AR, stream R beats until rlast
  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    case (rstate_q)
      R_IDLE: if (rd_acc) begin
        rstate_d = R_ADDR;
        araddr_d = rd_addr;
        arlen_d  = burst_len(rd_type, LINE_BEATS);
        arsize_d = burst_size(rd_type);
      end
      R_ADDR: if (arready) rstate_d = R_DATA;
      R_DATA: if (rvalid && rlast) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write FSM: AW and W complete independently, in any order, before B
  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wstate_q)
      W_IDLE: if (wr_acc) begin
        wstate_d  = W_SEND;
        awaddr_d  = wr_addr;
        awlen_d   = burst_len(wr_type, LINE_BEATS);
        awsize_d  = burst_size(wr_type);
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      W_SEND: begin
        if (aw_hs)    aw_done_d = 1'b1;
        if (wlast_hs) w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || wlast_hs)) wstate_d = W_RESP;
      end
      W_RESP: if (bvalid) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Sticky error on any non-OKAY accepted R or B response
  always_comb begin
    err_d = err_q;
    if (rvalid && rready && (rresp != 2'b00)) err_d = 1'b1;
    if (bvalid && bready && (bresp != 2'b00)) err_d = 1'b1;
  end

  axi_wbeat_ser #(
    .LINE_BEATS(LINE_BEATS)
  ) u_wbeat_ser (
    .clk      (clk),
    .reset    (reset),
    .load_i   (wr_acc),
    .line_i   (wr_data),
    .wstrb_i  (wr_wstrb),
    .is_line_i(wr_type == TYPE_LINE),
    .len_i    (awlen_q),
    .step_i   (wvalid && wready),
    .wdata_o  (wdata),
    .wstrb_o  (wstrb),
    .wlast_o  (wlast)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: table-driven single transactions
// plus hand-written concurrency, hazard and reset sequences; returned read
// beats and W beats are checked against queues filled when stimulus is driven.
module tb_cache_axi_bridge;
  import cache_axi_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req, rd_rdy, ret_valid, ret_last;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr, ret_data;
  logic         wr_req, wr_rdy;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic [3:0]   arid, awid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;
  logic         axi_err;

  always #5 clk = ~clk;

  cache_axi_bridge #(.AXI_ID(4'd1), .LINE_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .axi_err(axi_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] data; logic last; } ret_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
  ret_t   ret_q[$];
  wbeat_t w_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returned read beats against expectations pushed when R beats are driven
  always @(negedge clk) begin
    ret_t e;
    if (!reset && ret_valid) begin
      if (ret_q.size() == 0) fail("ret_unexpected");
      else begin
        e = ret_q.pop_front();
        chk("ret_data", ret_data, e.data);
        chk("ret_last", ret_last, e.last);
      end
    end
  end

  // Accepted W beats against expectations pushed when a write is issued
  always @(negedge clk) begin
    wbeat_t e;
    if (!reset && wvalid && wready) begin
      if (w_q.size() == 0) fail("wbeat_unexpected");
      else begin
        e = w_q.pop_front();
        chk("wdata", wdata, e.data);
        chk("wstrb", wstrb, e.strb);
        chk("wlast", wlast, e.last);
      end
    end
  end

  task automatic rd_accept(input logic [2:0] t, input logic [31:0] a);
    bit ok = 0;
    int n = 0;
    rd_req = 1; rd_type = t; rd_addr = a;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = rd_rdy;
      tick();
      n++;
    end
    rd_req = 0;
    if (!ok) fail("rd_accept_timeout");
  endtask

  task automatic wr_accept(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                           input logic [127:0] d);
    bit ok = 0;
    int n = 0;
    wr_req = 1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = wr_rdy;
      tick();
      n++;
    end
    wr_req = 0;
    if (!ok) fail("wr_accept_timeout");
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input int dly);
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, a);
    chk("arlen", arlen, len);
    chk("arsize", arsize, sz);
    chk("arburst", arburst, 2'b01);
    chk("arid", arid, 4'd1);
    repeat (dly) begin
      tick();
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, a);
    end
    arready = 1;
    tick();
    arready = 0;
    chk("arvalid_drop", arvalid, 0);
  endtask

  task automatic r_phase(input int nb, input logic [31:0] base, input logic [1:0] resp);
    for (int i = 0; i < nb; i++) begin
      ret_q.push_back('{data: base + 32'(i), last: (i == nb - 1)});
      rvalid = 1; rdata = base + 32'(i); rlast = (i == nb - 1); rresp = resp;
      chk("rready", rready, 1);
      tick();
    end
    rvalid = 0; rlast = 0; rresp = 0;
    chk("rready_idle", rready, 0);
  endtask

  task automatic aw_check(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, a);
    chk("awlen", awlen, len);
    chk("awsize", awsize, sz);
    chk("awburst", awburst, 2'b01);
    chk("awid", awid, 4'd1);
    chk("wr_rdy_busy", wr_rdy, 0);
  endtask

  task automatic w_phase(input logic [127:0] d, input int nb, input logic [3:0] s,
                         input int aw_dly, input bit toggle);
    bit aw_seen = 0;
    bit resp = 0;
    int cyc = 0;
    for (int i = 0; i < nb; i++)
      w_q.push_back('{data: d[i*32 +: 32], strb: s, last: (i == nb - 1)});
    while (!resp && cyc < 60) begin
      awready = (cyc >= aw_dly);
      wready  = toggle ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      if (awvalid && awready) aw_seen = 1;
      tick();
      cyc++;
      if (bready) resp = 1;
    end
    awready = 0; wready = 0;
    if (!resp) fail("w_resp_timeout");
    chk("aw_before_resp", aw_seen, 1);
    chk("wbeats_left", w_q.size(), 0);
  endtask

  task automatic b_phase(input int dly, input logic [1:0] resp);
    repeat (dly) begin
      chk("wr_rdy_wait", wr_rdy, 0);
      chk("bready", bready, 1);
      tick();
    end
    bvalid = 1; bresp = resp;
    tick();
    bvalid = 0; bresp = 0;
    chk("wr_rdy_after_b", wr_rdy, 1);
  endtask

  typedef struct {
    bit           is_wr;
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
    int           dly;
    logic [1:0]   resp;
    logic [7:0]   e_len;
    logic [2:0]   e_size;
    logic [3:0]   e_strb;
    bit           e_err;
  } vec_t;

  localparam logic [127:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LINE_B = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
  localparam logic [127:0] LINE_C = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

  initial begin
    vec_t vt[8];
    vt[0] = '{0, 3'b000, 32'h0000_0101, 4'h0, 128'h11, 0, 2'b00, 8'd0, 3'd0, 4'h0, 0};
    vt[1] = '{0, 3'b001, 32'h0000_0202, 4'h0, 128'h22, 1, 2'b00, 8'd0, 3'd1, 4'h0, 0};
    vt[2] = '{0, 3'b010, 32'h0000_0304, 4'h0, 128'h33, 0, 2'b00, 8'd0, 3'd2, 4'h0, 0};
    vt[3] = '{0, 3'b100, 32'h1C00_0010, 4'h0, 128'hA,  2, 2'b00, 8'd3, 3'd2, 4'h0, 0};
    vt[4] = '{1, 3'b000, 32'h0000_0403, 4'h8, 128'hEE, 0, 2'b00, 8'd0, 3'd0, 4'h8, 0};
    vt[5] = '{1, 3'b010, 32'hBFAF_8000, 4'h3, 128'h1234_5678, 1, 2'b00, 8'd0, 3'd2, 4'h3, 0};
    vt[6] = '{1, 3'b100, 32'h0000_0500, 4'h0, LINE_A, 8, 2'b00, 8'd3, 3'd2, 4'hf, 0};
    vt[7] = '{0, 3'b010, 32'h0000_0600, 4'h0, 128'h77, 0, 2'b10, 8'd0, 3'd2, 4'h0, 1};

    reset = 1;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
    arready = 0; rid = 4'd1; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;

    // Reset state before any clock edge
    #2;
    chk("rst_rd_rdy", rd_rdy, 1);
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_axi_err", axi_err, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Table-driven single transactions
    for (int v = 0; v < 8; v++) begin
      if (!vt[v].is_wr) begin
        rd_accept(vt[v].typ, vt[v].addr);
        ar_phase(vt[v].addr, vt[v].e_len, vt[v].e_size, vt[v].dly);
        r_phase(int'(vt[v].e_len) + 1, vt[v].data[31:0], vt[v].resp);
      end else begin
        wr_accept(vt[v].typ, vt[v].addr, vt[v].strb, vt[v].data);
        aw_check(vt[v].addr, vt[v].e_len, vt[v].e_size);
        w_phase(vt[v].data, int'(vt[v].e_len) + 1, vt[v].e_strb, vt[v].dly,
                vt[v].typ == 3'b100);
        b_phase(2, vt[v].resp);
      end
      chk("axi_err_vec", axi_err, vt[v].e_err);
    end

    // Incoming write to the same line blocks a read combinationally
    wr_req = 1; wr_addr = 32'h0000_5000; rd_addr = 32'h0000_5008;
    #1 chk("rd_rdy_wrreq_same_line", rd_rdy, 0);
    rd_addr = 32'h0000_6008;
    #1 chk("rd_rdy_wrreq_other_line", rd_rdy, 1);
    wr_req = 0;
    tick();

    // Pending write to 0x1000 holds off a read to 0x1004 until bvalid
    wr_accept(3'b010, 32'h0000_1000, 4'hf, 128'hCAFE_F00D);
    aw_check(32'h0000_1000, 8'd0, 3'd2);
    w_phase(128'hCAFE_F00D, 1, 4'hf, 0, 0);
    rd_req = 1; rd_type = 3'b010; rd_addr = 32'h0000_1004;
    repeat (3) begin
      @(negedge clk);
      chk("hazard_rd_rdy", rd_rdy, 0);
      chk("hazard_arvalid", arvalid, 0);
      tick();
    end
    bvalid = 1;
    @(negedge clk);
    chk("hazard_rd_rdy_b", rd_rdy, 0);
    tick();
    bvalid = 0;
    @(negedge clk);
    chk("hazard_clear_rd_rdy", rd_rdy, 1);
    chk("hazard_clear_arvalid", arvalid, 0);
    tick();
    rd_req = 0;
    ar_phase(32'h0000_1004, 8'd0, 3'd2, 0);
    r_phase(1, 32'h5151_0000, 2'b00);

    // Same-cycle line write and line read to different lines
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h0000_2000; wr_wstrb = 4'h0; wr_data = LINE_B;
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h0000_3000;
    @(negedge clk);
    chk("both_rd_rdy", rd_rdy, 1);
    chk("both_wr_rdy", wr_rdy, 1);
    tick();
    wr_req = 0; rd_req = 0;
    chk("both_arvalid", arvalid, 1);
    chk("both_awvalid", awvalid, 1);
    chk("both_wvalid", wvalid, 1);
    ar_phase(32'h0000_3000, 8'd3, 3'd2, 1);
    r_phase(4, 32'h0000_0300, 2'b00);
    aw_check(32'h0000_2000, 8'd3, 3'd2);
    w_phase(LINE_B, 4, 4'hf, 0, 0);
    b_phase(0, 2'b00);

    // Fresh error state, then an error bresp ahead of the mid-burst reset
    #2 reset = 1;
    #1 chk("rst2_axi_err", axi_err, 0);
    tick();
    reset = 0;
    wr_accept(3'b010, 32'h0000_7000, 4'hf, 128'h7);
    w_phase(128'h7, 1, 4'hf, 0, 0);
    b_phase(0, 2'b10);
    chk("bresp_err", axi_err, 1);

    // Line write stalled at beat 2 with a line read in address phase
    wr_accept(3'b100, 32'h0000_8000, 4'h0, LINE_C);
    rd_accept(3'b100, 32'h0000_9000);
    w_q.push_back('{data: LINE_C[31:0], strb: 4'hf, last: 1'b0});
    w_q.push_back('{data: LINE_C[63:32], strb: 4'hf, last: 1'b0});
    wready = 1;
    tick();
    tick();
    wready = 0;
    chk("mid_wdata_beat2", wdata, LINE_C[95:64]);
    chk("mid_arvalid", arvalid, 1);
    chk("mid_axi_err", axi_err, 1);
    #2 reset = 1;
    #1;
    chk("async_arvalid", arvalid, 0);
    chk("async_awvalid", awvalid, 0);
    chk("async_wvalid", wvalid, 0);
    chk("async_rready", rready, 0);
    chk("async_bready", bready, 0);
    chk("async_ret_valid", ret_valid, 0);
    chk("async_axi_err", axi_err, 0);
    chk("async_rd_rdy", rd_rdy, 1);
    chk("async_wr_rdy", wr_rdy, 1);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // After reset the beat counter starts again from the first word
    wr_accept(3'b100, 32'h0000_A000, 4'h0, LINE_A);
    aw_check(32'h0000_A000, 8'd3, 3'd2);
    w_phase(LINE_A, 4, 4'hf, 2, 0);
    b_phase(1, 2'b00);
    chk("final_axi_err", axi_err, 0);

    chk("ret_q_empty", ret_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
